// File: rtl/sat_bcp_pkg.sv
// rtl/sat_bcp_pkg.sv - literal/value codes, sequencer state encoding and popcount helper
package sat_bcp_pkg;

    localparam logic [1:0] LIT_ABSENT = 2'b00;
    localparam logic [1:0] LIT_POS    = 2'b01;
    localparam logic [1:0] LIT_NEG    = 2'b10;

    localparam logic [1:0] V_FREE  = 2'b00;
    localparam logic [1:0] V_FALSE = 2'b01;
    localparam logic [1:0] V_TRUE  = 2'b10;

    typedef logic [2:0] bcp_state_t;

    localparam bcp_state_t S_IDLE  = 3'd0;
    localparam bcp_state_t S_LOAD  = 3'd1;
    localparam bcp_state_t S_EVAL  = 3'd2;
    localparam bcp_state_t S_MERGE = 3'd3;
    localparam bcp_state_t S_NEXT  = 3'd4;
    localparam bcp_state_t S_DONE  = 3'd5;

    // Code 2'b11 is reserved and behaves like an absent literal.
    function automatic logic lit_present(input logic [1:0] lit);
        return (lit == LIT_POS) || (lit == LIT_NEG);
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] mask);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'b0000, mask[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bcp_var_table.sv
// rtl/bcp_var_table.sv - variable assignment register file with host write and masked merge
module bcp_var_table
    import sat_bcp_pkg::*;
#(
    parameter int NUM_VARS = 8,
    parameter int VI_W     = $clog2(NUM_VARS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [VI_W-1:0]       wr_idx,
    input  logic [2:0]            wr_val,
    input  logic                  merge_en,
    input  logic [NUM_VARS-1:0]   merge_mask,
    input  logic [NUM_VARS*3-1:0] merge_vals,
    output logic [NUM_VARS*3-1:0] table_o,
    output logic [NUM_VARS-1:0]   field_conflict_o,
    output logic [NUM_VARS-1:0]   field_update_o
);

    logic [2:0] tbl [NUM_VARS];

    // Only free entries accept an implied value; a non-free entry must agree with the return.
    always_comb begin
        table_o          = '0;
        field_conflict_o = '0;
        field_update_o   = '0;
        for (int k = 0; k < NUM_VARS; k++) begin
            table_o[3*k +: 3]   = tbl[k];
            field_update_o[k]   = merge_mask[k] && merge_vals[3*k+2]
                                  && (merge_vals[3*k +: 2] != V_FREE)
                                  && (tbl[k][1:0] == V_FREE);
            field_conflict_o[k] = merge_mask[k]
                                  && (merge_vals[3*k +: 2] != V_FREE)
                                  && (tbl[k][1:0] != V_FREE)
                                  && (merge_vals[3*k +: 2] != tbl[k][1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_VARS; k++) begin
                tbl[k] <= 3'b000;
            end
        end else begin
            if (wr_en) begin
                tbl[wr_idx] <= wr_val;
            end
            if (merge_en) begin
                for (int k = 0; k < NUM_VARS; k++) begin
                    if (field_update_o[k]) begin
                        tbl[k] <= {1'b1, merge_vals[3*k +: 2]};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/bcp_sequencer.sv
// rtl/bcp_sequencer.sv - streams stored clauses through the clause evaluator and merges implications
// Optional build macro BCP_FIXPOINT_EN: repeat passes until one makes no change.
module bcp_sequencer
    import sat_bcp_pkg::*;
#(
    parameter int NUM_VARS    = 8,
    parameter int NUM_CLAUSES = 16,
    parameter int CA_W        = $clog2(NUM_CLAUSES),
    parameter int VI_W        = $clog2(NUM_VARS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cl_wr_i,
    input  logic [CA_W-1:0]       cl_addr_i,
    input  logic [NUM_VARS*2-1:0] cl_lits_i,
    input  logic [CA_W:0]         num_clauses_i,
    input  logic                  var_wr_i,
    input  logic [VI_W-1:0]       var_idx_i,
    input  logic [2:0]            var_val_i,
    output logic [NUM_VARS*3-1:0] var_table_o,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  conflict_o,
    output logic                  ce_wr_o,
    output logic [NUM_VARS*3-1:0] ce_var_value_o,
    output logic [4:0]            ce_clause_len_o,
    input  logic [NUM_VARS*3-1:0] ce_var_value_i,
    input  logic                  ce_conflict_i
);

    bcp_state_t              state;
    logic [CA_W-1:0]         ptr;
    logic [CA_W:0]           count;
    logic                    change;
    logic                    conflict_q;
    logic [NUM_VARS*3-1:0]   samp_vals;
    logic                    samp_conf;
    logic [NUM_VARS*2-1:0]   clause_mem [NUM_CLAUSES];
    logic [NUM_VARS*2-1:0]   cur_lits;
    logic [NUM_VARS-1:0]     present;
    logic [NUM_VARS-1:0]     field_conflict;
    logic [NUM_VARS-1:0]     field_update;
    logic                    idle;
    logic                    merge_conflict;
    logic                    merge_commit;

    assign idle           = (state == S_IDLE);
    assign cur_lits       = clause_mem[ptr];
    assign merge_conflict = samp_conf || (|field_conflict);
    assign merge_commit   = (state == S_MERGE) && !merge_conflict;
    assign busy_o         = !idle;
    assign done_o         = (state == S_DONE);
    assign conflict_o     = conflict_q;

    always_comb begin
        present = '0;
        for (int k = 0; k < NUM_VARS; k++) begin
            present[k] = lit_present(cur_lits[2*k +: 2]);
        end
    end

    bcp_var_table #(
        .NUM_VARS (NUM_VARS),
        .VI_W     (VI_W)
    ) u_table (
        .clk              (clk),
        .rst              (rst),
        .wr_en            (idle && var_wr_i),
        .wr_idx           (var_idx_i),
        .wr_val           (var_val_i),
        .merge_en         (merge_commit),
        .merge_mask       (present),
        .merge_vals       (samp_vals),
        .table_o          (var_table_o),
        .field_conflict_o (field_conflict),
        .field_update_o   (field_update)
    );

    // Clause store has no reset; the host loads it before starting.
    always_ff @(posedge clk) begin
        if (idle && cl_wr_i) begin
            clause_mem[cl_addr_i] <= cl_lits_i;
        end
    end

    always_comb begin
        ce_wr_o         = (state == S_LOAD);
        ce_var_value_o  = '0;
        ce_clause_len_o = '0;
        if (state == S_LOAD) begin
            for (int k = 0; k < NUM_VARS; k++) begin
                ce_var_value_o[3*k +: 3] = {1'b0, cur_lits[2*k +: 2]};
            end
            ce_clause_len_o = popcount16(16'(present));
        end else if (state == S_EVAL) begin
            for (int k = 0; k < NUM_VARS; k++) begin
                ce_var_value_o[3*k +: 3] = present[k] ? var_table_o[3*k +: 3] : 3'b000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            count      <= '0;
            change     <= 1'b0;
            conflict_q <= 1'b0;
            samp_vals  <= '0;
            samp_conf  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        count      <= num_clauses_i;
                        ptr        <= '0;
                        change     <= 1'b0;
                        conflict_q <= 1'b0;
                        state      <= (num_clauses_i == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: state <= S_EVAL;
                S_EVAL: begin
                    samp_vals <= ce_var_value_i;
                    samp_conf <= ce_conflict_i;
                    state     <= S_MERGE;
                end
                S_MERGE: begin
                    if (merge_conflict) begin
                        conflict_q <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        if (|field_update) begin
                            change <= 1'b1;
                        end
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (({1'b0, ptr} + 1'b1) < count) begin
                        ptr   <= ptr + 1'b1;
                        state <= S_LOAD;
                    end else begin
`ifdef BCP_FIXPOINT_EN
                        if (change) begin
                            change <= 1'b0;
                            ptr    <= '0;
                            state  <= S_LOAD;
                        end else begin
                            state <= S_DONE;
                        end
`else
                        state <= S_DONE;
`endif
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcp_sequencer.sv
// tb/tb_bcp_sequencer.sv - randomized and directed bench with unit-propagation evaluator and pass-level model
module tb_bcp_sequencer;

    localparam int NV  = 8;
    localparam int NC  = 16;
    localparam int CAW = 4;
`ifdef BCP_FIXPOINT_EN
    localparam bit FIXPT = 1'b1;
`else
    localparam bit FIXPT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cl_wr_i = 1'b0;
    logic [CAW-1:0]  cl_addr_i = '0;
    logic [15:0]     cl_lits_i = '0;
    logic [CAW:0]    num_clauses_i = '0;
    logic            var_wr_i = 1'b0;
    logic [2:0]      var_idx_i = '0;
    logic [2:0]      var_val_i = '0;
    logic [23:0]     var_table_o;
    logic            start_i = 1'b0;
    logic            busy_o, done_o, conflict_o, ce_wr_o;
    logic [23:0]     ce_var_value_o;
    logic [4:0]      ce_clause_len_o;
    logic [23:0]     ce_var_value_i;
    logic            ce_conflict_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] cls_q [NC];
    logic [23:0] tab_q;

    logic [15:0] ev_lits = '0;
    int          ev_cnt = 0;
    int          inj_clause = -1;
    bit          ovr_en = 1'b0;
    int          ovr_idx = 0;
    logic [2:0]  ovr_val = '0;
    logic [23:0] ev_o;
    bit          ev_c;

    bcp_sequencer dut (
        .clk(clk), .rst(rst), .cl_wr_i(cl_wr_i), .cl_addr_i(cl_addr_i), .cl_lits_i(cl_lits_i),
        .num_clauses_i(num_clauses_i), .var_wr_i(var_wr_i), .var_idx_i(var_idx_i),
        .var_val_i(var_val_i), .var_table_o(var_table_o), .start_i(start_i), .busy_o(busy_o),
        .done_o(done_o), .conflict_o(conflict_o), .ce_wr_o(ce_wr_o),
        .ce_var_value_o(ce_var_value_o), .ce_clause_len_o(ce_clause_len_o),
        .ce_var_value_i(ce_var_value_i), .ce_conflict_i(ce_conflict_i)
    );

    always #5 clk = ~clk;

    // Unit-propagation clause evaluator: echoes present values, implies the last free literal.
    function automatic void eval_clause(input logic [15:0] lits, input logic [23:0] vals,
                                        output logic [23:0] outv, output bit conf);
        int nfree, fidx, npres;
        bit sat;
        logic [1:0] l, v;
        nfree = 0; fidx = -1; npres = 0; sat = 1'b0; outv = '0;
        for (int k = 0; k < NV; k++) begin
            l = lits[2*k +: 2];
            v = vals[3*k +: 2];
            if (l == 2'b01 || l == 2'b10) begin
                npres++;
                outv[3*k +: 3] = vals[3*k +: 3];
                if (v == 2'b00) begin
                    nfree++;
                    fidx = k;
                end else if ((l == 2'b01 && v == 2'b10) || (l == 2'b10 && v == 2'b01)) begin
                    sat = 1'b1;
                end
            end
        end
        conf = (npres > 0) && !sat && (nfree == 0);
        if (!sat && nfree == 1)
            outv[3*fidx +: 3] = {1'b1, (lits[2*fidx +: 2] == 2'b01) ? 2'b10 : 2'b01};
    endfunction

    always @(posedge clk) begin
        if (rst || (start_i && !busy_o)) begin
            ev_cnt <= 0;
        end else if (ce_wr_o) begin
            ev_cnt <= ev_cnt + 1;
            for (int k = 0; k < NV; k++) ev_lits[2*k +: 2] <= ce_var_value_o[3*k +: 2];
        end
    end

    always_comb begin
        ev_o = '0;
        ev_c = 1'b0;
        eval_clause(ev_lits, ce_var_value_o, ev_o, ev_c);
        if (ovr_en) ev_o[3*ovr_idx +: 3] = ovr_val;
        ce_var_value_i = ev_o;
        ce_conflict_i  = ev_c || (inj_clause >= 0 && ev_cnt - 1 == inj_clause);
    end

    // Pass-level model: walk clauses in order, apply merge rules, count 4 cycles per clause.
    function automatic void model_run(input logic [23:0] tab_in, input int n, input int inj,
                                      input bit ovr, input int oidx, input logic [2:0] oval,
                                      output logic [23:0] tab_out, output bit conf, output int lat);
        logic [23:0] tab, masked, o;
        logic [1:0]  l, rv, tv;
        int cyc, gcnt;
        bit chg, c;
        tab = tab_in; cyc = 0; gcnt = 0; conf = 1'b0; lat = 1; tab_out = tab;
        if (n == 0) return;
        for (int p = 0; p < NV + 2; p++) begin
            chg = 1'b0;
            for (int i = 0; i < n; i++) begin
                masked = '0;
                for (int k = 0; k < NV; k++) begin
                    l = cls_q[i][2*k +: 2];
                    if (l == 2'b01 || l == 2'b10) masked[3*k +: 3] = tab[3*k +: 3];
                end
                eval_clause(cls_q[i], masked, o, c);
                if (ovr) o[3*oidx +: 3] = oval;
                if (gcnt == inj) c = 1'b1;
                gcnt++;
                for (int k = 0; k < NV; k++) begin
                    l = cls_q[i][2*k +: 2]; rv = o[3*k +: 2]; tv = tab[3*k +: 2];
                    if ((l == 2'b01 || l == 2'b10) && rv != 0 && tv != 0 && rv != tv) c = 1'b1;
                end
                if (c) begin
                    conf = 1'b1; lat = cyc + 4; tab_out = tab;
                    return;
                end
                for (int k = 0; k < NV; k++) begin
                    l = cls_q[i][2*k +: 2];
                    if ((l == 2'b01 || l == 2'b10) && o[3*k+2] && o[3*k +: 2] != 0
                        && tab[3*k +: 2] == 0) begin
                        tab[3*k +: 3] = {1'b1, o[3*k +: 2]};
                        chg = 1'b1;
                    end
                end
                cyc += 4;
            end
            if (!FIXPT || !chg) break;
        end
        lat = cyc + 1;
        tab_out = tab;
    endfunction

    function automatic logic [15:0] mk_clause(input int k1, input logic [1:0] c1,
                                              input int k2, input logic [1:0] c2);
        logic [15:0] c;
        c = '0;
        c[2*k1 +: 2] = c1;
        c[2*k2 +: 2] = c2;
        return c;
    endfunction

    task automatic do_reset();
        rst = 1'b1; inj_clause = -1; ovr_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tab_q = '0;
    endtask

    task automatic write_clause(input int addr, input logic [15:0] lits);
        cl_wr_i = 1'b1; cl_addr_i = CAW'(addr); cl_lits_i = lits;
        @(posedge clk);
        #1 cl_wr_i = 1'b0;
        cls_q[addr] = lits;
    endtask

    task automatic write_var(input int idx, input logic [2:0] val);
        var_wr_i = 1'b1; var_idx_i = 3'(idx); var_val_i = val;
        @(posedge clk);
        #1 var_wr_i = 1'b0;
        tab_q[3*idx +: 3] = val;
    endtask

    task automatic run_pass(input int n, output int lat, output bit busy_ok,
                            output logic load_wr, output logic [4:0] load_len);
        num_clauses_i = (CAW+1)'(n);
        start_i = 1'b1; lat = -1; busy_ok = 1'b1; load_wr = 1'b0; load_len = '0;
        for (int c = 1; c <= 1000; c++) begin
            @(posedge clk);
            #1 start_i = 1'b0; var_wr_i = 1'b0;
            @(negedge clk);
            if (c == 1) begin load_wr = ce_wr_o; load_len = ce_clause_len_o; end
            if (!busy_o) busy_ok = 1'b0;
            if (done_o) begin lat = c; break; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({busy_o, done_o, conflict_o, ce_wr_o} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy_o, done_o, conflict_o, ce_wr_o});
        end
        n_checks++;
        if (ce_var_value_o !== 24'h0 || ce_clause_len_o !== 5'd0) begin
            n_fail++; $display("FAIL reset_ce: got %h/%0d expected 0/0", ce_var_value_o, ce_clause_len_o);
        end
        n_checks++;
        if (var_table_o !== 24'h0) begin
            n_fail++; $display("FAIL reset_table: got %h expected 000000", var_table_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_pass();
        int lat; bit bok; logic lw; logic [4:0] ll; logic [23:0] exp_tab;
        do_reset();
        write_clause(0, mk_clause(1, 2'b01, 5, 2'b10));
        var_wr_i = 1'b1; var_idx_i = 3'd1; var_val_i = 3'b001;
        run_pass(1, lat, bok, lw, ll);
        exp_tab = '0; exp_tab[5:3] = 3'b001; exp_tab[17:15] = 3'b101;
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL single_latency: got %0d expected 5", lat); end
        n_checks++;
        if (var_table_o !== exp_tab) begin
            n_fail++; $display("FAIL single_table: got %h expected %h", var_table_o, exp_tab);
        end
        n_checks++;
        if (conflict_o !== 1'b0) begin n_fail++; $display("FAIL single_conflict: got %b expected 0", conflict_o); end
        n_checks++;
        if (!bok || lw !== 1'b1 || ll !== 5'd2) begin
            n_fail++; $display("FAIL single_load: busy_ok %b wr %b len %0d expected 1 1 2", bok, lw, ll);
        end
    endtask

    task automatic test_conflict_flag();
        int lat; bit bok; logic lw; logic [4:0] ll; logic [23:0] exp_tab;
        do_reset();
        write_var(0, 3'b010);
        write_clause(0, mk_clause(0, 2'b10, 1, 2'b01));
        write_clause(1, mk_clause(1, 2'b01, 2, 2'b00));
        write_clause(2, mk_clause(1, 2'b10, 7, 2'b01));
        write_clause(3, mk_clause(6, 2'b01, 6, 2'b01));
        inj_clause = 2;
        run_pass(4, lat, bok, lw, ll);
        inj_clause = -1;
        exp_tab = '0; exp_tab[2:0] = 3'b010; exp_tab[5:3] = 3'b110;
        n_checks++;
        if (lat !== 12 || conflict_o !== 1'b1) begin
            n_fail++; $display("FAIL conflict_flag: got lat %0d conf %b expected 12 1", lat, conflict_o);
        end
        n_checks++;
        if (var_table_o !== exp_tab) begin
            n_fail++; $display("FAIL conflict_table: got %h expected %h", var_table_o, exp_tab);
        end
        @(negedge clk);
        n_checks++;
        if (conflict_o !== 1'b1) begin n_fail++; $display("FAIL conflict_hold: got %b expected 1", conflict_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_disagree();
        int lat; bit bok; logic lw; logic [4:0] ll;
        do_reset();
        write_var(3, 3'b010);
        write_clause(0, mk_clause(3, 2'b01, 6, 2'b01));
        ovr_en = 1'b1; ovr_idx = 3; ovr_val = 3'b101;
        run_pass(1, lat, bok, lw, ll);
        ovr_en = 1'b0;
        n_checks++;
        if (conflict_o !== 1'b1 || lat !== 4) begin
            n_fail++; $display("FAIL disagree_conflict: got conf %b lat %0d expected 1 4", conflict_o, lat);
        end
        n_checks++;
        if (var_table_o !== 24'h000400) begin
            n_fail++; $display("FAIL disagree_table: got %h expected 000400", var_table_o);
        end
    endtask

    task automatic test_fixpoint();
        int lat; bit bok; logic lw; logic [4:0] ll; logic [23:0] exp_tab; int exp_lat;
        do_reset();
        write_var(0, 3'b010);
        write_clause(0, mk_clause(2, 2'b01, 4, 2'b10));
        write_clause(1, mk_clause(4, 2'b01, 0, 2'b10));
        run_pass(2, lat, bok, lw, ll);
        exp_tab = '0; exp_tab[2:0] = 3'b010; exp_tab[14:12] = 3'b110;
        exp_lat = 9;
        if (FIXPT) begin
            exp_tab[8:6] = 3'b110;
            exp_lat = 25;
        end
        n_checks++;
        if (var_table_o !== exp_tab) begin
            n_fail++; $display("FAIL fixpoint_table: got %h expected %h", var_table_o, exp_tab);
        end
        n_checks++;
        if (lat !== exp_lat || conflict_o !== 1'b0) begin
            n_fail++; $display("FAIL fixpoint_latency: got %0d conf %b expected %0d 0", lat, conflict_o, exp_lat);
        end
    endtask

    task automatic test_reset_mid_pass();
        bit saw_done;
        do_reset();
        write_var(0, 3'b010);
        write_clause(0, mk_clause(0, 2'b10, 1, 2'b01));
        num_clauses_i = 5'd1;
        start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0 || var_table_o !== 24'h0) begin
            n_fail++; $display("FAIL rst_mid_pass: got busy %b table %h expected 0 000000", busy_o, var_table_o);
        end
        saw_done = done_o;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_o) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rst_no_done: got %b expected 0", saw_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_and_busy_writes();
        int lat; bit bok; logic lw; logic [4:0] ll;
        do_reset();
        num_clauses_i = '0;
        start_i = 1'b1;
        @(posedge clk); #1;
        var_wr_i = 1'b1; var_idx_i = 3'd7; var_val_i = 3'b010;
        @(negedge clk);
        n_checks++;
        if (done_o !== 1'b1 || conflict_o !== 1'b0) begin
            n_fail++; $display("FAIL zero_done: got done %b conf %b expected 1 0", done_o, conflict_o);
        end
        @(posedge clk); #1 var_wr_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || var_table_o !== 24'h0) begin
            n_fail++; $display("FAIL done_cycle_ignore: got busy %b done %b table %h expected 0 0 000000",
                               busy_o, done_o, var_table_o);
        end
        @(posedge clk); #1;
        write_clause(0, 16'h0000);
        fork
            run_pass(1, lat, bok, lw, ll);
            begin
                @(posedge clk); @(posedge clk); #2;
                var_wr_i = 1'b1; var_idx_i = 3'd6; var_val_i = 3'b010;
                @(posedge clk); #2 var_wr_i = 1'b0;
            end
        join
        n_checks++;
        if (var_table_o !== 24'h0 || lat !== 5) begin
            n_fail++; $display("FAIL busy_write_ignored: got table %h lat %0d expected 000000 5", var_table_o, lat);
        end
    endtask

    task automatic test_random();
        int lat, n, inj, exp_lat; bit bok, exp_conf; logic lw; logic [4:0] ll;
        logic [23:0] exp_tab; logic [15:0] c; logic [1:0] v;
        do_reset();
        for (int it = 0; it < 24; it++) begin
            for (int a = 0; a < NC; a++) begin
                c = '0;
                for (int k = 0; k < NV; k++)
                    if ($urandom_range(0, 3) == 0) c[2*k +: 2] = 2'($urandom_range(1, 3));
                write_clause(a, c);
            end
            for (int k = 0; k < NV; k++) begin
                v = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
                write_var(k, {(v != 0) ? 1'($urandom_range(0, 1)) : 1'b0, v});
            end
            n = (it % 8 == 7) ? 0 : int'($urandom_range(1, NC));
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
            model_run(tab_q, n, inj, 1'b0, 0, 3'b000, exp_tab, exp_conf, exp_lat);
            inj_clause = inj;
            run_pass(n, lat, bok, lw, ll);
            inj_clause = -1;
            tab_q = exp_tab;
            n_checks++;
            if (var_table_o !== exp_tab) begin
                n_fail++; $display("FAIL rand_table[%0d]: got %h expected %h", it, var_table_o, exp_tab);
            end
            n_checks++;
            if (conflict_o !== exp_conf) begin
                n_fail++; $display("FAIL rand_conflict[%0d]: got %b expected %b", it, conflict_o, exp_conf);
            end
            n_checks++;
            if (lat !== exp_lat || !bok) begin
                n_fail++; $display("FAIL rand_latency[%0d]: got %0d busy_ok %b expected %0d 1", it, lat, bok, exp_lat);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < NC; a++) cls_q[a] = '0;
        tab_q = '0;
        test_reset();
        test_single_pass();
        test_conflict_flag();
        test_disagree();
        test_fixpoint();
        test_reset_mid_pass();
        test_zero_and_busy_writes();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
